// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the ThinPad instruction-fetch stage: bus defaults,
// fetch-state encoding and the IF/ID register layout.
package inst_fetch_unit_pkg;

    localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
    localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
    localparam logic [1:0]  DEF_ADDR_HI   = 2'b00;

    localparam logic [0:0] ST_ADDR    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pc_plus1;
        logic [15:0] instr;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/inst_fetch_unit_pc_unit.sv
// Program counter: holds pc, offers pc+1, and selects between reset value,
// branch target, hold and increment.
module inst_fetch_unit_pc_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_branch,
    input  logic [15:0] i_target,
    input  logic        i_inc,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus1
);

    logic [15:0] r_pc;
    logic [15:0] w_pc_plus1;

    // Natural 16-bit wrap: 16'hFFFF + 1 = 16'h0000.
    assign w_pc_plus1 = r_pc + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_branch) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus1 = w_pc_plus1;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch for the 16-bit ThinPad CPU: two-phase RAM1 read
// (ADDR then CAPTURE), yields the bus on mem_conflict, feeds IF/ID.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [1:0]  ADDR_HI   = DEF_ADDR_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        mem_conflict,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    input  logic [15:0] ram_data_in,
    output logic [17:0] ram_addr,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic [15:0] if_instr,
    output logic        if_valid
);

    logic [0:0]  r_state;
    logic [17:0] r_ram_addr;
    logic        r_ram_en_n;
    logic        r_ram_oe_n;
    ifid_t       r_ifid;

    logic [15:0] w_pc;
    logic [15:0] w_pc_plus1;
    logic        w_capture;

    assign w_capture = (r_state == ST_CAPTURE) && !mem_conflict && !stall_in && !branch_valid;

    inst_fetch_unit_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst        (rst),
        .i_branch   (branch_valid),
        .i_target   (branch_target),
        .i_inc      (w_capture),
        .o_pc       (w_pc),
        .o_pc_plus1 (w_pc_plus1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_ADDR;
            r_ram_addr     <= 18'd0;
            r_ram_en_n     <= 1'b1;
            r_ram_oe_n     <= 1'b1;
            r_ifid.pc      <= 16'h0000;
            r_ifid.pc_plus1 <= 16'h0001;
            r_ifid.instr   <= NOP_INSTR;
            r_ifid.valid   <= 1'b0;
        end else if (branch_valid) begin
            // Redirect wins over stall and conflict; any in-flight read is dropped.
            r_state      <= ST_ADDR;
            r_ram_en_n   <= 1'b1;
            r_ram_oe_n   <= 1'b1;
            r_ifid.instr <= NOP_INSTR;
            r_ifid.valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (mem_conflict) begin
                        r_ram_en_n <= 1'b1;
                        r_ram_oe_n <= 1'b1;
                    end else begin
                        r_ram_addr <= {ADDR_HI, w_pc};
                        r_ram_en_n <= 1'b0;
                        r_ram_oe_n <= 1'b0;
                        r_state    <= ST_CAPTURE;
                    end
                end
                default: begin
                    r_ram_en_n <= 1'b1;
                    r_ram_oe_n <= 1'b1;
                    r_state    <= ST_ADDR;
                    if (w_capture) begin
                        r_ifid.instr    <= ram_data_in;
                        r_ifid.pc       <= w_pc;
                        r_ifid.pc_plus1 <= w_pc_plus1;
                        r_ifid.valid    <= 1'b1;
                    end else if (mem_conflict && !stall_in) begin
                        r_ifid.instr <= NOP_INSTR;
                        r_ifid.valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_en_n    = r_ram_en_n;
    assign ram_oe_n    = r_ram_oe_n;
    assign ram_we_n    = 1'b1;
    assign if_pc       = r_ifid.pc;
    assign if_pc_plus1 = r_ifid.pc_plus1;
    assign if_instr    = r_ifid.instr;
    assign if_valid    = r_ifid.valid;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit ThinPad CPU; sits directly upstream of the data-memory stage on the shared RAM1 bus.
- Owns the PC and runs a two-phase SRAM read of the instruction word from RAM1, using the same ADDR/CAPTURE cadence as the data-memory stage.
- Yields the bus whenever that stage raises its memory-conflict flag.
- Delivers {pc, pc+1, instr, valid} to the IF/ID boundary; supports hazard stall and branch redirect.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction driven when no valid fetch is held.
- ADDR_HI, 2'b00, constant upper bits of ram_addr[17:16].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- stall_in  in  1  ID-stage hazard stall; holds PC and IF/ID outputs.
- mem_conflict  in  1  data stage owns RAM1 this cycle; fetch must release the bus.
- branch_valid  in  1  one-cycle redirect request.
- branch_target  in  16  redirect PC.
- ram_data_in  in  16  RAM1 data bus (read only; this block never drives it).
- ram_addr  out  18  RAM1 address, registered.
- ram_en_n  out  1  RAM1 chip enable, active-low, registered.
- ram_oe_n  out  1  RAM1 output enable, active-low, registered.
- ram_we_n  out  1  RAM1 write enable, tied inactive (1).
- if_pc  out  16  PC of held instruction.
- if_pc_plus1  out  16  if_pc + 1, modulo 2^16.
- if_instr  out  16  fetched instruction or NOP_INSTR.
- if_valid  out  1  if_instr is a real fetch.

Behaviour:
- Reset values (asynchronous, rst=1):
  - pc=RESET_PC, state=ADDR.
  - ram_addr=0, ram_en_n=1, ram_oe_n=1, ram_we_n=1.
  - if_pc=0, if_pc_plus1=1, if_instr=NOP_INSTR, if_valid=0.
- States: ADDR, CAPTURE. Each successful fetch takes 2 cycles, so peak throughput is 1 instruction per 2 clk.
- ADDR, mem_conflict=0:
  - ram_addr<={ADDR_HI,pc}, ram_en_n<=0, ram_oe_n<=0.
  - state<=CAPTURE.
- ADDR, mem_conflict=1:
  - ram_en_n<=1, ram_oe_n<=1.
  - Stay in ADDR; pc unchanged.
- CAPTURE, mem_conflict=0 and stall_in=0:
  - if_instr<=ram_data_in, if_pc<=pc, if_pc_plus1<=pc+1, if_valid<=1.
  - pc<=pc+1 (16'hFFFF wraps to 16'h0000).
  - Release the bus (en_n/oe_n<=1); state<=ADDR.
- CAPTURE, mem_conflict=1:
  - Discard the data; pc unchanged.
  - Release the bus; state<=ADDR; same PC is refetched.
  - IF/ID outputs: if stall_in=1, hold; if stall_in=0, load a bubble (if_instr<=NOP_INSTR, if_valid<=0).
- CAPTURE, stall_in=1 and mem_conflict=0:
  - Discard the data; pc unchanged; IF/ID outputs held.
  - Release the bus; state<=ADDR; same PC is refetched.
- ADDR, stall_in=1: IF/ID outputs hold; bus behaviour is unchanged.
- ADDR, stall_in=0 and no capture this cycle: IF/ID outputs hold. Between fetches, if_valid keeps its last value; ID consumes each instruction once via its own handshake.
- Branch (branch_valid=1, any state):
  - Highest priority below reset; overrides stall_in and mem_conflict.
  - pc<=branch_target; state<=ADDR.
  - ram_en_n/oe_n<=1.
  - Flush: if_instr<=NOP_INSTR, if_valid<=0.
  - Any in-flight fetch is dropped.
  - First fetch of the target reaches IF/ID 2 cycles after the branch cycle, absent conflicts.
- Reset asserted mid-fetch: the bus is released immediately (async); no partial instruction is latched.
- ram_we_n is never 0.

Decomposition:
- Shared package: NOP_INSTR, RESET_PC, ADDR_HI defaults, fetch-state encoding (ADDR=1'b0, CAPTURE=1'b1).
- One sub-module, pc_unit: holds pc, computes pc+1, and muxes between reset, branch_target, hold and increment.
- FSM, bus control and IF/ID register stay in the top.

Test Plan:
- Reset release, RAM1[0]=16'h6801, RAM1[1]=16'h4A02, no stalls -> if_instr=16'h6801 with if_pc=0 and if_valid=1 at cycle 2; 16'h4A02 with if_pc=1 at cycle 4.
- mem_conflict held for 3 cycles starting in ADDR with pc=5 -> ram_en_n=1 throughout; no capture; fetch of pc=5 completes 2 cycles after conflict drops.
- stall_in high in CAPTURE with pc=7 -> if_instr/if_pc held; pc stays 7; refetch of 7 after stall drops; no instruction lost or duplicated.
- branch_valid with target=16'h0100 during CAPTURE while stall_in=1 -> if_valid=0 and if_instr=16'h0800 next cycle; next valid if_pc=16'h0100.
- pc=16'hFFFF fetch -> if_pc=16'hFFFF, if_pc_plus1=16'h0000; next fetch address 18'h00000.
- rst asserted in CAPTURE -> ram_en_n=ram_oe_n=1 and if_valid=0 without waiting for clk; restart at RESET_PC.
